scan_seq_4_16: RTL and testbench

- Registered scan sequencer that drives the select and active-low enable inputs of the 4-to-16 active-low-enable decoder.
- Steps a 4-bit channel index from a programmable first to last channel.
- Holds each channel enabled for a programmable dwell time, with an optional blanking gap between channels.
- Runs either continuously or as a single pass. Typical use is LED-matrix or keypad row scanning.

---
 rtl/scan_pkg.sv | 25 ++
 rtl/scan_dwell_cnt.sv | 26 ++
 rtl/scan_seq_4_16.sv | 143 ++++++++++++++
 tb/tb_scan_seq_4_16.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the 4-to-16 scan sequencer.
// The channel constants are also used by the decoder it drives.
package scan_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_BLANK  = 2'd2;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_BLANK  = ST_BLANK
  } state_t;

  // Channel advance wraps naturally through 15 -> 0.
  function automatic logic [SEL_W-1:0] next_ch(
    input logic [SEL_W-1:0] c
  );
    return c + 1'b1;
  endfunction

endpackage

// File: rtl/scan_dwell_cnt.sv
// Loadable down-counter that stops at zero.
// Shared by the dwell and blanking phases of the scan sequencer.
module scan_dwell_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/scan_seq_4_16.sv
// Registered scan sequencer driving a 4-to-16 decoder's select and
// active-low enable, with programmable dwell and blanking gap.
module scan_seq_4_16
  import scan_pkg::*;
#(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic               stop_in,
  input  logic               mode_in,
  input  logic [SEL_W-1:0]   first_in,
  input  logic [SEL_W-1:0]   last_in,
  input  logic [DWELL_W-1:0] dwell_in,
  output logic [SEL_W-1:0]   sel_out,
  output logic               en_n_out,
  output logic               busy_out,
  output logic               wrap_out,
  output logic               done_out
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int CW = (DWELL_W > BW) ? DWELL_W : BW;
  localparam logic [CW-1:0] BLANK_M1 =
    CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  state_t           state;
  logic             mode_q;
  logic [SEL_W-1:0] first_q;
  logic [SEL_W-1:0] last_q;
  logic [CW-1:0]    dwell_m1;

  logic [CW-1:0]    in_m1;
  logic             cnt_load;
  logic [CW-1:0]    cnt_val;
  logic [CW-1:0]    remain_unused;
  logic             cnt_zero;
  logic             at_last;

  // A zero dwell request behaves as a single-cycle dwell.
  always_comb begin
    in_m1 = '0;
    if (dwell_in != '0) in_m1 = CW'(dwell_in - 1'b1);
  end

  assign at_last = (sel_out == last_q);

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = dwell_m1;
    unique case (state)
      S_IDLE: begin
        cnt_load = start_in;
        cnt_val  = in_m1;
      end
      S_ACTIVE: begin
        cnt_load = cnt_zero;
        if (BLANK_CYC > 0) cnt_val = BLANK_M1;
      end
      S_BLANK: begin
        cnt_load = cnt_zero;
      end
      default: ;
    endcase
  end

  scan_dwell_cnt #(
    .W (CW)
  ) u_cnt (
    .clk      (clk_in),
    .rst      (rst_in),
    .load     (cnt_load),
    .load_val (cnt_val),
    .value    (remain_unused),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= S_IDLE;
      sel_out  <= '0;
      en_n_out <= 1'b1;
      busy_out <= 1'b0;
      wrap_out <= 1'b0;
      done_out <= 1'b0;
      mode_q   <= 1'b0;
      first_q  <= '0;
      last_q   <= '0;
      dwell_m1 <= '0;
    end else begin
      wrap_out <= 1'b0;
      done_out <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_in && !stop_in) begin
            mode_q   <= mode_in;
            first_q  <= first_in;
            last_q   <= last_in;
            dwell_m1 <= in_m1;
            sel_out  <= first_in;
            en_n_out <= 1'b0;
            busy_out <= 1'b1;
            state    <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (stop_in || (cnt_zero && at_last && mode_q)) begin
            state    <= S_IDLE;
            en_n_out <= 1'b1;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end else if (cnt_zero) begin
            sel_out  <= at_last ? first_q : next_ch(sel_out);
            wrap_out <= at_last;
            if (BLANK_CYC > 0) begin
              state    <= S_BLANK;
              en_n_out <= 1'b1;
            end
          end
        end
        S_BLANK: begin
          if (stop_in) begin
            state    <= S_IDLE;
            en_n_out <= 1'b1;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end else if (cnt_zero) begin
            state    <= S_ACTIVE;
            en_n_out <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          en_n_out <= 1'b1;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_seq_4_16.sv
// Scoreboard bench: three sequencers (blank gap 1, 0, 2) checked
// cycle by cycle against a precomputed scan-trace reference model.
module tb_scan_seq_4_16;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [3:0] first, last;
  logic [7:0] dwell;

  logic [3:0] sel_o  [3];
  logic       en_o   [3];
  logic       busy_o [3];
  logic       wrap_o [3];
  logic       done_o [3];

  always #5 clk = ~clk;

  scan_seq_4_16 #(.DWELL_W(8), .BLANK_CYC(1)) u0 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .stop_in(stop),
    .mode_in(mode), .first_in(first), .last_in(last),
    .dwell_in(dwell), .sel_out(sel_o[0]), .en_n_out(en_o[0]),
    .busy_out(busy_o[0]), .wrap_out(wrap_o[0]), .done_out(done_o[0])
  );

  scan_seq_4_16 #(.DWELL_W(8), .BLANK_CYC(0)) u1 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .stop_in(stop),
    .mode_in(mode), .first_in(first), .last_in(last),
    .dwell_in(dwell), .sel_out(sel_o[1]), .en_n_out(en_o[1]),
    .busy_out(busy_o[1]), .wrap_out(wrap_o[1]), .done_out(done_o[1])
  );

  scan_seq_4_16 #(.DWELL_W(8), .BLANK_CYC(2)) u2 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .stop_in(stop),
    .mode_in(mode), .first_in(first), .last_in(last),
    .dwell_in(dwell), .sel_out(sel_o[2]), .en_n_out(en_o[2]),
    .busy_out(busy_o[2]), .wrap_out(wrap_o[2]), .done_out(done_o[2])
  );

  typedef struct packed {
    logic [3:0] sel;
    logic       en_n;
    logic       busy;
    logic       wrap;
    logic       done;
  } rec_t;

  rec_t plan [3][$];
  rec_t expq [3][$];
  rec_t cur  [3];

  int checks   = 0;
  int failures = 0;

  function automatic int blank_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
  endfunction

  function automatic rec_t mk(input logic [3:0] s, input logic e,
                              input logic b, input logic w,
                              input logic d);
    rec_t r;
    r.sel  = s;
    r.en_n = e;
    r.busy = b;
    r.wrap = w;
    r.done = d;
    return r;
  endfunction

  // Expected per-cycle outputs of a whole scan, from its configuration.
  task automatic build(input int i, input logic [3:0] f,
                       input logic [3:0] l, input logic [7:0] d,
                       input logic m);
    logic [3:0] span;
    int eff, nch, bl, p;
    span = l - f;
    nch  = int'(span) + 1;
    eff  = (d == 8'd0) ? 1 : int'(d);
    bl   = blank_of(i);
    p    = 0;
    plan[i].delete();
    do begin
      for (int k = 0; k < nch; k++) begin
        logic [3:0] ch;
        ch = f + 4'(k);
        if (p > 0 || k > 0)
          for (int j = 0; j < bl; j++)
            plan[i].push_back(mk(ch, 1'b1, 1'b1, k == 0 && j == 0, 1'b0));
        for (int j = 0; j < eff; j++)
          plan[i].push_back(mk(ch, 1'b0, 1'b1,
                               bl == 0 && k == 0 && p > 0 && j == 0, 1'b0));
      end
      p++;
    end while (!m && plan[i].size() < 200);
    if (m) plan[i].push_back(mk(l, 1'b1, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic step(input logic r, input logic s, input logic p,
                      input logic m, input logic [3:0] f,
                      input logic [3:0] l, input logic [7:0] d);
    rec_t nx;
    rst = r; start = s; stop = p; mode = m;
    first = f; last = l; dwell = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        nx = mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        plan[i].delete();
      end else if (cur[i].busy) begin
        if (p || plan[i].size() == 0) begin
          nx = mk(cur[i].sel, 1'b1, 1'b0, 1'b0, 1'b1);
          plan[i].delete();
        end else begin
          nx = plan[i].pop_front();
        end
      end else if (s && !p) begin
        build(i, f, l, d, m);
        nx = plan[i].pop_front();
      end else begin
        nx = mk(cur[i].sel, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      expq[i].push_back(nx);
      cur[i] = nx;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++)
      step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
           4'($urandom), 4'($urandom), 8'($urandom));
  endtask

  task automatic junk(input int n, input logic s);
    for (int c = 0; c < n; c++)
      step(1'b0, s, 1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
           8'($urandom_range(0, 3)));
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (expq[i].size() > 0) begin
        rec_t e, g;
        e = expq[i].pop_front();
        g = mk(sel_o[i], en_o[i], busy_o[i], wrap_o[i], done_o[i]);
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL out_u%0d t=%0t got sel=%0d en_n=%b busy=%b wrap=%b done=%b want sel=%0d en_n=%b busy=%b wrap=%b done=%b",
                   i, $time, g.sel, g.en_n, g.busy, g.wrap, g.done,
                   e.sel, e.en_n, e.busy, e.wrap, e.done);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    first = 4'd0; last = 4'd0; dwell = 8'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd9, 8'd2);
    idle(2);

    // Reset during a dwell.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 8'd4);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 8'd4);
    idle(3);

    // Single pass 2..4, dwell 3.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd4, 8'd3);
    idle(16);

    // Continuous 14..1 through the 15->0 wrap, then stop.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd14, 4'd1, 8'd1);
    idle(12);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'd0);
    idle(2);

    // Zero dwell on a single channel.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd5, 8'd0);
    idle(6);

    // Stop on the same edge as the 1->14 wrap (gapless instance).
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd14, 4'd1, 8'd1);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'd0);
    idle(2);

    // Start together with stop is refused.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd6, 8'd2);
    idle(3);

    // Start and config churn while busy are ignored.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 4'd9, 8'd2);
    for (int c = 0; c < 5; c++)
      step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)),
           4'($urandom), 4'($urandom), 8'($urandom));
    idle(8);

    // Randomized scans with random stops, restarts and resets.
    for (int t = 0; t < 40; t++) begin
      step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)),
           4'($urandom), 4'($urandom), 8'($urandom_range(0, 3)));
      junk($urandom_range(1, 40), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0)
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'($urandom), 4'($urandom), 8'd1);
      idle($urandom_range(1, 3));
    end

    idle(3);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (expq[i].size() != 0) begin
        failures++;
        $display("FAIL drain_u%0d pending=%0d want 0", i, expq[i].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
